// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised FIFO.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2; clog2(1) == 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Pointer width: enough bits to index DEPTH entries, never less than one
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read (distributed RAM).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and selectable registered or FWFT read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  parameter int FWFT         = MODE_STD,
  localparam int CW          = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             push_ok, pop_ok;

  // Explicit wrap so non-power-of-two depths use every entry
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags come straight from the count register, not pointer equality
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AFULL_LEVEL);
  assign almost_empty = (int'(count) <= AEMPTY_LEVEL);

  // A push into a full FIFO is still accepted when a pop frees a slot this cycle
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, occupancy and rejection pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push & ~push_ok;
      underflow <= pop & ~pop_ok;
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word shown directly; zero while empty so reset leaves data_out at 0
      assign data_out   = empty ? '0 : rd_data;
      assign data_valid = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;

      // Registered read: capture head on accepted pop, hold otherwise
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= pop_ok;
          if (pop_ok) data_reg <= rd_data;
        end
      end

      assign data_out   = data_reg;
      assign data_valid = valid_reg;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; successor to the fixed 2-entry, 8-bit FIFO used across the ECP5 designs. It generalises width and depth and adds occupancy count, almost-full/almost-empty thresholds, overflow/underflow reporting and a selectable first-word-fall-through (FWFT) read mode. All state updates on clk; no edge-triggered push/pop. Sits between byte/word producers (UART RX, SPI) and consumers in the fabric.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer; all DEPTH entries usable)
AFULL_LEVEL, DEPTH-2, almost_full asserted when count >= AFULL_LEVEL
AEMPTY_LEVEL, 2, almost_empty asserted when count <= AEMPTY_LEVEL
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
push  input  1  write request, sampled on rising clk
data_in  input  WIDTH  write data, sampled with push
pop  input  1  read request, sampled on rising clk
data_out  output  WIDTH  read data
data_valid  output  1  data_out holds valid word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_LEVEL
almost_empty  output  1  count <= AEMPTY_LEVEL
count  output  CW  occupancy, CW = clog2(DEPTH+1)
overflow  output  1  one-cycle pulse: push rejected
underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Reset (sync, clk edge with reset=1): wr_ptr=rd_ptr=0, count=0, data_out=0, data_valid=0, overflow=underflow=0; empty=1, full=0, almost_empty=1, almost_full=(AFULL_LEVEL==0). Reset overrides push/pop in the same cycle; memory contents not cleared.
- Pointers wrap at DEPTH-1 -> 0 (explicit compare, not modulo of power of two).
- Full/empty derived from count register, not pointer equality: all DEPTH entries usable.
- push accepted iff !full, or full and pop accepted same cycle. Accepted push: mem[wr_ptr]<=data_in, wr_ptr advances.
- pop accepted iff !empty. Accepted pop: rd_ptr advances.
- count: +1 push only, -1 pop only, unchanged when both or neither accepted.
- Rejected push: overflow=1 next cycle for one cycle, no state change. Rejected pop: underflow=1 likewise.
- Full + push + pop: both accepted, count stays DEPTH, no overflow.
- Empty + push + pop: push accepted, pop rejected (underflow pulse), count becomes 1.
- Standard mode (FWFT=0): accepted pop registers mem[rd_ptr] into data_out; data_valid=1 the cycle after, 0 otherwise; data_out holds last value when no pop.
- FWFT mode: data_out = mem[rd_ptr] combinationally, data_valid = !empty; pop consumes the shown word; new head visible same cycle pointer updates. Word written into empty FIFO appears at data_out one cycle after push.
- Flags are combinational from count; all update on the same edge as count.

Decomposition:
- Package fifo_pkg: clog2 constant function, PTR_W/CNT_W derivation helpers, FWFT mode constants (MODE_STD=0, MODE_FWFT=1).
- One sub-module fifo_mem: DEPTH x WIDTH dual-port array, synchronous write, asynchronous read; maps to ECP5 distributed RAM. Control, pointers, count and flags stay in sync_fifo_param.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, data_valid=0, almost_empty=1, no pulses.
- FWFT=0, DEPTH=4: push 0x11,0x22,0x33,0x44 -> full=1, count=4; 5th push 0x55 -> overflow pulse, count stays 4; four pops -> data_out 0x11,0x22,0x33,0x44 each with data_valid one cycle after pop; then empty=1.
- Pop on empty -> underflow one cycle, count 0, data_out unchanged.
- Full + simultaneous push 0xAA/pop -> no overflow, count stays DEPTH, 0xAA later read in order after remaining words (wrap-around check, pointers cross DEPTH-1 -> 0 over 3 fills).
- FWFT=1: push 0x5A into empty -> next cycle data_out=0x5A, data_valid=1 without pop; pop -> data_valid=0, empty=1.
- Reset asserted mid-stream with push=pop=1 and count=3 -> next cycle count=0, empty=1, data_valid=0; thresholds DEPTH=16, AFULL_LEVEL=14: almost_full rises exactly when count reaches 14.
